// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants and FSM state type for the sequencer table loader
package seq_pkg;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_FRAME = 4;
    localparam int FRAME_W         = WORD_W * WORDS_PER_FRAME;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        READY
    } state_e;
endpackage

// File: rtl/seq_table_ram.sv
// rtl/seq_table_ram.sv - simple dual-port frame RAM, one write port, registered read port
module seq_table_ram
    import seq_pkg::*;
#(
    parameter int AW = 10,
    parameter int W  = FRAME_W
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] r_mem [0:(2**AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= r_mem[raddr_i];
        end
    end
endmodule

// File: rtl/seq_table_loader.sv
// rtl/seq_table_loader.sv - packs table register writes into 128-bit frames and serves them to the sequencer
module seq_table_loader
    import seq_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               TABLE_START,
    input  logic [31:0]        TABLE_DATA,
    input  logic               TABLE_WSTB,
    input  logic [15:0]        TABLE_LENGTH,
    input  logic               TABLE_LENGTH_WSTB,
    input  logic               rd_req_i,
    input  logic               rd_rst_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic               frame_vld_o,
    output logic [AW:0]        table_frames_o,
    output logic               table_ready_o,
    output logic               load_err_o
);
    // Word counter must reach exactly 4*DEPTH, hence two extra bits plus one for the full flag.
    localparam int CW = AW + 3;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CW-1:0]           r_word_cnt;
    logic                    r_ovf;
    logic [2:0][WORD_W-1:0]  r_stage;
    logic [AW-1:0]           r_rd_ptr;
    logic                    r_rd_p1;

    logic                    w_loading;
    logic                    w_ready;
    logic                    w_full;
    logic                    w_word;
    logic                    w_commit;
    logic                    w_len_ok;
    logic                    w_we;
    logic [FRAME_W-1:0]      w_wdata;
    logic                    w_rd_go;
    logic [AW-1:0]           w_rd_addr;
    logic                    w_rd_last;
    logic [FRAME_W-1:0]      w_ram_q;

    assign w_loading = (r_state == LOADING);
    assign w_ready   = (r_state == READY);
    assign w_full    = r_word_cnt[CW-1];
    assign w_word    = w_loading && TABLE_WSTB && !TABLE_START;
    assign w_commit  = w_loading && TABLE_LENGTH_WSTB && !TABLE_START;
    assign w_len_ok  = (32'(TABLE_LENGTH) == 32'(r_word_cnt)) && (TABLE_LENGTH != 16'd0)
                       && (TABLE_LENGTH[1:0] == 2'd0) && !r_ovf;
    assign w_we      = w_word && !w_full && (r_word_cnt[1:0] == 2'd3);
    assign w_wdata   = {TABLE_DATA, r_stage[2], r_stage[1], r_stage[0]};

    assign w_rd_go   = w_ready && rd_req_i && !TABLE_START;
    assign w_rd_addr = rd_rst_i ? '0 : r_rd_ptr;
    assign w_rd_last = (({1'b0, w_rd_addr} + (AW+1)'(1)) == table_frames_o);

    assign table_ready_o = w_ready;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (TABLE_START) begin
            w_state_nxt = LOADING;
        end else if (w_commit) begin
            w_state_nxt = w_len_ok ? READY : IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_word_cnt     <= '0;
            r_ovf          <= 1'b0;
            r_stage        <= '0;
            r_rd_ptr       <= '0;
            r_rd_p1        <= 1'b0;
            frame_o        <= '0;
            frame_vld_o    <= 1'b0;
            table_frames_o <= '0;
            load_err_o     <= 1'b0;
        end else begin
            // A new load cancels any frame still travelling through the read pipeline.
            r_rd_p1     <= w_rd_go;
            frame_vld_o <= r_rd_p1 && !TABLE_START;
            if (r_rd_p1 && !TABLE_START) begin
                frame_o <= w_ram_q;
            end

            if (TABLE_START) begin
                r_word_cnt <= '0;
                r_ovf      <= 1'b0;
                load_err_o <= 1'b0;
            end else if (w_word) begin
                if (w_full) begin
                    r_ovf      <= 1'b1;
                    load_err_o <= 1'b1;
                end else begin
                    case (r_word_cnt[1:0])
                        2'd0:    r_stage[0] <= TABLE_DATA;
                        2'd1:    r_stage[1] <= TABLE_DATA;
                        2'd2:    r_stage[2] <= TABLE_DATA;
                        default: ;
                    endcase
                    r_word_cnt <= r_word_cnt + CW'(1);
                end
            end

            if (w_commit) begin
                if (w_len_ok) begin
                    table_frames_o <= r_word_cnt[AW+2:2];
                    r_rd_ptr       <= '0;
                end else begin
                    load_err_o <= 1'b1;
                end
            end else if (w_rd_go) begin
                r_rd_ptr <= w_rd_last ? '0 : w_rd_addr + AW'(1);
            end else if (rd_rst_i) begin
                r_rd_ptr <= '0;
            end
        end
    end

    seq_table_ram #(
        .AW (AW),
        .W  (FRAME_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .waddr_i (r_word_cnt[AW+1:2]),
        .wdata_i (w_wdata),
        .re_i    (w_rd_go),
        .raddr_i (w_rd_addr),
        .rdata_o (w_ram_q)
    );
endmodule
